// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter bundle for the uart_tx round-robin arbiter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   grant;
    logic                 busy;
    logic                 tx_data_en;
    logic [7:0]           tx_data;
    logic                 tx_done;
    logic                 err_timeout;

    modport slave (
        input  req_valid, req_data, req_last, tx_done,
        output req_ready, grant, busy, tx_data_en, tx_data, err_timeout
    );

    modport master (
        output req_valid, req_data, req_last, tx_done,
        input  req_ready, grant, busy, tx_data_en, tx_data, err_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one uart_tx among NUM_REQ clients.
// Define UART_ARB_TIMEOUT_EN to enable the WAIT-state watchdog abort.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input logic            clk,
    input logic            rst_n,
    uart_tx_arbiter_if.slave bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT, HOLD} state_t;

    state_t             state;
    logic [IW-1:0]      owner;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      pick;
    logic [IW-1:0]      owner_nxt;
    logic               pick_hit;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] ready;
    logic               en_q;
    logic [7:0]         data_q;
    logic               last_flag;
    logic               sel_valid;
    logic               sel_last;
    logic [7:0]         sel_data;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CW-1:0] cnt;
    logic          err_q;
`endif

    // Lowest-offset requester at or above ptr wins; scan high to low so it is written last.
    always_comb begin
        int j;
        logic [IW-1:0] cand;
        j        = 0;
        cand     = '0;
        pick_hit = 1'b0;
        pick     = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j    = (int'(ptr) + k) % NUM_REQ;
            cand = IW'(j);
            if (bus.req_valid[cand]) begin
                pick_hit = 1'b1;
                pick     = cand;
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = 8'h00;
        ready     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == IW'(i)) begin
                sel_valid = bus.req_valid[i];
                sel_last  = bus.req_last[i];
                sel_data  = bus.req_data[8*i +: 8];
                ready[i]  = (state == SEND);
            end
        end
    end

    assign owner_nxt = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= '0;
            ptr       <= '0;
            grant_q   <= '0;
            en_q      <= 1'b0;
            data_q    <= 8'h00;
            last_flag <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt       <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
`ifdef UART_ARB_TIMEOUT_EN
            err_q <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (pick_hit) begin
                        owner   <= pick;
                        grant_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    data_q    <= sel_data;
                    last_flag <= sel_last;
                    en_q      <= 1'b1;
                    state     <= WAIT;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt       <= '0;
`endif
                end
                WAIT: begin
                    if (bus.tx_done) begin
                        if (last_flag) begin
                            grant_q <= '0;
                            en_q    <= 1'b0;
                            ptr     <= owner_nxt;
                            state   <= IDLE;
                        end else if (sel_valid) begin
                            state <= SEND;
                        end else begin
                            en_q  <= 1'b0;
                            state <= HOLD;
                        end
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        err_q   <= 1'b1;
                        grant_q <= '0;
                        en_q    <= 1'b0;
                        ptr     <= owner_nxt;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                HOLD: begin
                    if (sel_valid) state <= SEND;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = ready;
    assign bus.grant      = grant_q;
    assign bus.busy       = (state != IDLE);
    assign bus.tx_data_en = en_q;
    assign bus.tx_data    = data_q;
`ifdef UART_ARB_TIMEOUT_EN
    assign bus.err_timeout = err_q;
`else
    assign bus.err_timeout = 1'b0;
`endif
endmodule
